// File: rtl/resource_arbiter.sv
// Round-robin arbiter that shares one single-issue resource among NUM_REQ requesters.
// Each transaction runs IDLE -> ISSUE -> WAIT -> DONE, with a timeout and a global flush.
module resource_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic                             rsp_err,
    output logic [DATA_W-1:0]                rsp_data,
    output logic [DATA_W-1:0]                res_in,
    output logic                             res_in_valid,
    input  logic [DATA_W-1:0]                res_out,
    input  logic                             res_out_valid
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        gidx_q, gidx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0]    res_in_q, res_in_d;
    logic                 res_in_valid_q, res_in_valid_d;

    logic                 found;
    logic [PW-1:0]        pick_idx;
    logic [PW-1:0]        cand;
    logic [PW-1:0]        next_ptr;
    int                   idx_c;

    // Scan from the pointer upward with wraparound; the first hit wins.
    always_comb begin
        found    = 1'b0;
        pick_idx = ptr_q;
        cand     = '0;
        idx_c    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_c = int'(ptr_q) + i;
            if (idx_c >= NUM_REQ) idx_c = idx_c - NUM_REQ;
            cand = PW'(idx_c);
            if (!found && req[cand]) begin
                found    = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign next_ptr = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        gidx_d         = gidx_q;
        cnt_d          = cnt_q;
        grant_d        = grant_q;
        rsp_valid_d    = '0;
        rsp_err_d      = 1'b0;
        rsp_data_d     = rsp_data_q;
        res_in_d       = res_in_q;
        res_in_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!flush && found) begin
                    gidx_d           = pick_idx;
                    grant_d          = '0;
                    grant_d[pick_idx] = 1'b1;
                    res_in_d         = req_data[pick_idx];
                    res_in_valid_d   = 1'b1;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (res_out_valid) begin
                    rsp_data_d  = res_out;
                    rsp_valid_d = grant_q;
                    state_d     = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = grant_q;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                grant_d = '0;
                ptr_d   = next_ptr;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything; the aborted requester loses its turn.
        if (flush && state_q != S_IDLE) begin
            state_d        = S_IDLE;
            grant_d        = '0;
            rsp_valid_d    = '0;
            rsp_err_d      = 1'b0;
            rsp_data_d     = rsp_data_q;
            res_in_valid_d = 1'b0;
            ptr_d          = next_ptr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            gidx_q         <= '0;
            cnt_q          <= '0;
            grant_q        <= '0;
            rsp_valid_q    <= '0;
            rsp_err_q      <= 1'b0;
            rsp_data_q     <= '0;
            res_in_q       <= '0;
            res_in_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            gidx_q         <= gidx_d;
            cnt_q          <= cnt_d;
            grant_q        <= grant_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_err_q      <= rsp_err_d;
            rsp_data_q     <= rsp_data_d;
            res_in_q       <= res_in_d;
            res_in_valid_q <= res_in_valid_d;
        end
    end

    assign grant        = grant_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_data     = rsp_data_q;
    assign res_in       = res_in_q;
    assign res_in_valid = res_in_valid_q;

endmodule

// File: tb/tb_resource_arbiter.sv
// Directed bench for resource_arbiter: flush, single request, wrap, timeout,
// async reset mid-transaction and round-robin fairness.
module tb_resource_arbiter;
    logic              clk;
    logic              reset;
    logic              flush;
    logic [3:0]        req;
    logic [3:0][31:0]  req_data;
    logic [3:0]        grant;
    logic [3:0]        rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_data;
    logic [31:0]       res_in;
    logic              res_in_valid;
    logic [31:0]       res_out;
    logic              res_out_valid;

    int n_chk  = 0;
    int n_fail = 0;

    resource_arbiter #(.NUM_REQ(4), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .req(req), .req_data(req_data),
        .grant(grant), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .res_in(res_in), .res_in_valid(res_in_valid),
        .res_out(res_out), .res_out_valid(res_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, ".grant"}, 64'(grant), 64'h0);
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'h0);
        check({tag, ".rsp_err"}, 64'(rsp_err), 64'h0);
        check({tag, ".res_in_valid"}, 64'(res_in_valid), 64'h0);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; req = '0; req_data = '0;
        res_out = '0; res_out_valid = 1'b0;
        req_data[0] = 32'h0000_0ABC;
        req_data[1] = 32'h1111_1111;
        req_data[2] = 32'hDEAD_BEEF;
        req_data[3] = 32'h3333_3333;

        // Reset state
        step();
        check_idle_outs("rst");
        check("rst.rsp_data", 64'(rsp_data), 64'h0);
        check("rst.res_in", 64'(res_in), 64'h0);
        reset = 1'b1;
        req   = 4'b0011;

        // Flush during WAIT, then requester 1 is served
        step();
        check("fl.grant0", 64'(grant), 64'h1);
        check("fl.issue", 64'(res_in_valid), 64'h1);
        step();
        flush = 1'b1;
        step();
        check_idle_outs("fl.after");
        flush = 1'b0;
        step();
        check("fl.grant1", 64'(grant), 64'h2);
        check("fl.res_in1", 64'(res_in), 64'h1111_1111);
        step();
        res_out_valid = 1'b1; res_out = 32'h77;
        step();
        check("fl.rsp_valid", 64'(rsp_valid), 64'h2);
        check("fl.rsp_data", 64'(rsp_data), 64'h77);
        res_out_valid = 1'b0; req = '0;
        step();
        check_idle_outs("fl.idle");

        // Single request, resource answers three cycles after issue
        req = 4'b0100;
        step();
        check("sr.grant", 64'(grant), 64'h4);
        check("sr.res_in", 64'(res_in), 64'hDEAD_BEEF);
        check("sr.issue", 64'(res_in_valid), 64'h1);
        step();
        check("sr.issue_1cyc", 64'(res_in_valid), 64'h0);
        check("sr.grant_held", 64'(grant), 64'h4);
        step();
        step();
        res_out_valid = 1'b1; res_out = 32'h1234;
        step();
        check("sr.rsp_valid", 64'(rsp_valid), 64'h4);
        check("sr.rsp_data", 64'(rsp_data), 64'h1234);
        check("sr.rsp_err", 64'(rsp_err), 64'h0);
        check("sr.grant_done", 64'(grant), 64'h4);
        res_out_valid = 1'b0; req = '0;
        step();
        check_idle_outs("sr.idle");

        // Pointer at 3: requester 3 wins over 0, then drops req mid-WAIT
        req = 4'b1001;
        step();
        check("wr.grant3", 64'(grant), 64'h8);
        check("wr.res_in3", 64'(res_in), 64'h3333_3333);
        step();
        req = 4'b0001;
        step();
        res_out_valid = 1'b1; res_out = 32'hAA;
        step();
        check("wr.rsp_valid3", 64'(rsp_valid), 64'h8);
        check("wr.rsp_data3", 64'(rsp_data), 64'hAA);
        res_out_valid = 1'b0;
        step();
        check("wr.gap", 64'(grant), 64'h0);
        step();
        check("wr.grant0", 64'(grant), 64'h1);
        check("wr.res_in0", 64'(res_in), 64'h0ABC);

        // Same transaction never answered: timeout after 16 WAIT cycles
        for (int i = 0; i < 16; i++) step();
        check("to.not_yet", 64'(rsp_valid), 64'h0);
        step();
        check("to.rsp_valid", 64'(rsp_valid), 64'h1);
        check("to.rsp_err", 64'(rsp_err), 64'h1);
        check("to.rsp_data", 64'(rsp_data), 64'h0);
        res_out_valid = 1'b1; res_out = 32'h5555; req = '0;
        step();
        check_idle_outs("to.late");
        check("to.late_data", 64'(rsp_data), 64'h0);
        res_out_valid = 1'b0;

        // Async reset in WAIT (pointer was 1), then arbitration restarts at 0
        req = 4'b0010;
        step();
        check("ar.grant1", 64'(grant), 64'h2);
        step();
        #2 reset = 1'b0;
        #1;
        check_idle_outs("ar.async");
        check("ar.res_in", 64'(res_in), 64'h0);
        check("ar.rsp_data", 64'(rsp_data), 64'h0);
        req = 4'b1111;
        step();
        reset = 1'b1;

        // Fairness: all requesting, resource latency 1
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rr%0d.grant", k), 64'(grant), 64'(4'b0001 << (k % 4)));
            step();
            res_out_valid = 1'b1; res_out = 32'(k + 32'h100);
            step();
            check($sformatf("rr%0d.rsp_valid", k), 64'(rsp_valid), 64'(4'b0001 << (k % 4)));
            check($sformatf("rr%0d.rsp_data", k), 64'(rsp_data), 64'(k + 32'h100));
            res_out_valid = 1'b0;
            step();
            check($sformatf("rr%0d.rsp_1cyc", k), 64'(rsp_valid), 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
